bram_sdp_stream_reader: RTL and testbench
=========================================

Name: bram_sdp_stream_reader

Overview:
- Read-side master for an inferred simple-dual-port block RAM: drives `ra`/`rce` and captures `rq`.
- Turns a (start address, length) command into a valid/ready data stream.
- Sits between an SDP BRAM and downstream fabric logic.
- Absorbs the BRAM's 1-cycle registered read latency and downstream backpressure with a 2-entry output buffer, sustaining 1 beat/cycle.

Parameters:
- AWIDTH, 10, BRAM address width; address space 2^AWIDTH words.
- DWIDTH, 18, BRAM data width.

Ports:
- clk  input  1  single clock for all logic and the BRAM read port.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe, sampled on a rising clk edge when busy=0.
- start_addr  input  AWIDTH  first word address.
- length  input  AWIDTH+1  number of words to read, 0..2^AWIDTH.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse at command completion.
- ra  output  AWIDTH  BRAM read address.
- rce  output  1  BRAM read enable.
- rq  input  DWIDTH  BRAM read data; valid the cycle after rce=1.
- m_valid  output  1  output beat valid.
- m_data  output  DWIDTH  output beat data.
- m_last  output  1  marks the final beat of a command.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 (busy, done, ra, rce, m_valid, m_data, m_last); buffer emptied; in-flight read discarded; FSM to IDLE. Takes effect mid-command with no completion pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 and length>0: latch address and remaining=length; busy=1 next cycle; go to RUN.
  - start=1 and length=0: no reads; done=1 for exactly one cycle on the next cycle; busy stays 0; stay in IDLE.
- RUN:
  - Each cycle compute free = 2 - buf_count - inflight + (m_valid & m_ready).
  - rce=1 iff free>0 and remaining>0.
  - On each rce: ra = current address; address increments modulo 2^AWIDTH (wraps 2^AWIDTH-1 to 0); remaining decrements.
  - When remaining reaches 0: go to DRAIN.
- DRAIN: no rce; wait until inflight=0 and buffer empty.
- Completion: done pulses one cycle after the handshake of the beat carrying m_last; busy falls in the same cycle done rises; return to IDLE.
- Capture: inflight (1 bit) is set by rce. On the following edge, rq is written to the buffer tail with last = (this was the final read).
- Output: m_valid/m_data/m_last driven from buffer head, registered. A handshake (m_valid & m_ready) pops the head.
- Data stability: m_data and m_last must hold while m_valid=1 and m_ready=0.
- Simultaneous push and pop: count unchanged, order preserved.
- The buffer never overflows; the free rule guarantees it.
- Latency: start sampled at edge E0 → rce=1 in cycle E0+1 → rq captured at E0+2 → m_valid=1 from E0+3.
- Throughput: with m_ready held at 1, one beat per cycle after the first. N words complete with done at E0+N+3.
- start while busy=1: ignored, no effect on the current command.
- m_ready=0 for an extended period: at most 2 reads outstanding (buffer full). rce stays 0 until a pop.

Optional Feature:
- Macro: BRAM_SDP_STREAM_ABORT_EN.
- Defined: adds input `abort` (1 bit).
  - abort=1 in RUN or DRAIN: rce is suppressed immediately. remaining and the buffer are cleared on the next edge, and the in-flight rq is discarded.
  - m_valid=0 from the next cycle.
  - done pulses the cycle after abort; busy falls with it.
  - abort in IDLE: no effect.
  - abort and start in the same cycle while IDLE: start wins.
- Not defined: no abort port; commands always run to completion.

Test Plan:
- Preload mem[k]=k+0x100. start_addr=5, length=4, m_ready=1 → ra=5,6,7,8 on consecutive cycles; m_data 0x105..0x108 on 4 consecutive cycles from E0+3; m_last only on 0x108; done at E0+7.
- Wrap (AWIDTH=10): start_addr=1022, length=4 → ra sequence 1022,1023,0,1; data in the same order.
- Backpressure: length=6, m_ready toggles 1,0,0,1,... → never more than 2 reads outstanding; all 6 words delivered in order, none dropped or duplicated; m_data stable while stalled.
- length=0 → no rce; done pulses once on the next cycle; busy stays 0. Also: start=1 pulsed mid-command is ignored.
- Reset mid-command: rst_n=0 after 2 beats of a length=8 command → all outputs 0 immediately. After release, a new start_addr=0, length=2 command runs correctly.
- With BRAM_SDP_STREAM_ABORT_EN: abort after 3 beats of length=10 → rce=0 that cycle; no further beats; done pulses next cycle.

Source files
------------

// File: rtl/bram_sdp_stream_reader.sv
// Read-side master for an SDP block RAM: turns (start_addr, length) commands into a valid/ready stream.
// Optional command abort is enabled by defining BRAM_SDP_STREAM_ABORT_EN.
module bram_sdp_stream_reader #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [AWIDTH:0]   length,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] ra,
  output logic              rce,
  input  logic [DWIDTH-1:0] rq,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
`ifdef BRAM_SDP_STREAM_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH:0]   remaining;
  logic              inflight;
  logic              inflight_last;
  logic              done_r;

  // Two-entry buffer: out_* is the registered output stage, skid_* holds the second word.
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;
  logic              skid_valid;
  logic [DWIDTH-1:0] skid_data;
  logic              skid_last;

  logic              hs;
  logic              abort_now;
  logic              final_read;
  logic [2:0]        free;

`ifdef BRAM_SDP_STREAM_ABORT_EN
  assign abort_now = abort && (state != S_IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign hs         = out_valid & m_ready;
  assign final_read = (remaining == (AWIDTH+1)'(1));
  // Slots not yet claimed by buffered or in-flight words; a pop this cycle frees one.
  assign free       = 3'd2 + {2'b00, hs} - {2'b00, out_valid} - {2'b00, skid_valid} - {2'b00, inflight};
  assign rce        = (state == S_RUN) && (free != 3'd0) && (remaining != '0) && !abort_now;
  assign ra         = addr;
  assign busy       = (state != S_IDLE);
  assign done       = done_r;
  assign m_valid    = out_valid;
  assign m_data     = out_data;
  assign m_last     = out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= length;
            if (length != '0) state <= S_RUN;
            else              done_r <= 1'b1;
          end
        end
        S_RUN: begin
          if (rce) begin
            addr      <= addr + AWIDTH'(1);
            remaining <= remaining - (AWIDTH+1)'(1);
            if (final_read) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last-flagged beat is only ever popped after every read has been captured.
          if (hs && out_last) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (abort_now) begin
        state     <= S_IDLE;
        remaining <= '0;
        done_r    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
    end else if (abort_now) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
    end else begin
      inflight      <= rce;
      inflight_last <= rce && final_read;
      if (hs) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_last   <= skid_last;
          skid_valid <= inflight;
          if (inflight) begin
            skid_data <= rq;
            skid_last <= inflight_last;
          end
        end else begin
          out_valid <= inflight;
          if (inflight) begin
            out_data <= rq;
            out_last <= inflight_last;
          end
        end
      end else if (inflight) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= rq;
          out_last  <= inflight_last;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= rq;
          skid_last  <= inflight_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_sdp_stream_reader.sv
// Directed bench for bram_sdp_stream_reader with a BRAM model (mem[k] = k + 0x100) and a stream scoreboard.
module tb_bram_sdp_stream_reader;
  localparam int AW = 10;
  localparam int DW = 18;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ra;
  logic          rce;
  logic [DW-1:0] rq;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
`ifdef BRAM_SDP_STREAM_ABORT_EN
  logic          abort;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks;
  int failures;
  int done_cnt;
  int beats;
  int outstanding;
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] exp_ra [$];
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW:0]   e_ent;
  logic [3:0]    bp_pat;

  bram_sdp_stream_reader #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ra         (ra),
    .rce        (rce),
    .rq         (rq),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
`ifdef BRAM_SDP_STREAM_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rce) rq <= mem[ra];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: ra order, outstanding reads, beat order/last, data hold under stall, done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (prev_stall && m_valid) begin
        check("hold_data", 32'(m_data), 32'(prev_data));
        check("hold_last", 32'(m_last), 32'(prev_last));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (rce) begin
        if (exp_ra.size() == 0) check("unexpected_rce", 32'd1, 32'd0);
        else check("ra", 32'(ra), 32'(exp_ra.pop_front()));
        check("outstanding_le2", 32'((outstanding + 1 - ((m_valid && m_ready) ? 1 : 0)) <= 2), 32'd1);
      end
      if (m_valid && m_ready) begin
        beats++;
        if (exp_q.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else begin
          e_ent = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(e_ent[DW-1:0]));
          check("beat_last", 32'(m_last), 32'(e_ent[DW]));
        end
      end
      outstanding = outstanding + (rce ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic issue(input int a0, input int len);
    int a;
    for (int i = 0; i < len; i++) begin
      a = (a0 + i) % (1 << AW);
      exp_ra.push_back(AW'(a));
      exp_q.push_back({(i == len - 1), DW'(a + 32'h100)});
    end
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = AW'(a0);
    length     = (AW+1)'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check(tag, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic end_test(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_exp_ra_empty"}, 32'(exp_ra.size()), 32'd0);
    done_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ra"}, 32'(ra), 32'd0);
    check({tag, "_rce"}, 32'(rce), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit seen;
    int b0;
    checks = 0; failures = 0; done_cnt = 0; beats = 0; outstanding = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    bp_pat = 4'b1001;
    for (int k = 0; k < (1 << AW); k++) mem[k] = DW'(k + 32'h100);
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b1;
`ifdef BRAM_SDP_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic cycle-exact run: rce k=1..4, beats k=3..6, done k=7.
    issue(5, 4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("basic_rce_k%0d", k), 32'(rce), 32'(k <= 4));
      check($sformatf("basic_valid_k%0d", k), 32'(m_valid), 32'(k >= 3 && k <= 6));
      check($sformatf("basic_done_k%0d", k), 32'(done), 32'(k == 7));
      check($sformatf("basic_busy_k%0d", k), 32'(busy), 32'(k <= 6));
    end
    end_test("basic");

    issue(1022, 4);
    wait_done("wrap_done", 30);
    end_test("wrap");

    // Backpressure with m_ready pattern 1,0,0,1 and an ignored start while busy.
    issue(40, 6);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      m_ready = bp_pat[c % 4];
      if (c == 4) begin
        check("bp_busy_at_extra_start", 32'(busy), 32'd1);
        start = 1'b1; start_addr = AW'(500); length = (AW+1)'(3);
      end
      if (c == 5) start = 1'b0;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("bp_done_seen", 32'(seen), 32'd1);
    check("bp_busy_at_done", 32'(busy), 32'd0);
    start = 1'b0;
    m_ready = 1'b1;
    end_test("bp");

    // Zero length: no reads, single done pulse, busy never rises.
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = AW'(7); length = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_rce", 32'(rce), 32'd0);
    @(negedge clk);
    check("len0_done_low", 32'(done), 32'd0);
    check("len0_busy_low", 32'(busy), 32'd0);
    end_test("len0");

    // Reset mid-command after two beats, then a fresh command.
    b0 = beats;
    issue(20, 8);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      if (beats - b0 >= 2) break;
    end
    check("rst_two_beats", 32'(beats - b0 >= 2), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    exp_ra.delete();
    outstanding = 0;
    done_cnt = 0;
    @(posedge clk);
    #1;
    check_all_zero("midrst_held");
    rst_n = 1'b1;
    issue(0, 2);
    wait_done("post_rst_done", 20);
    end_test("post_rst");

`ifdef BRAM_SDP_STREAM_ABORT_EN
    b0 = beats;
    issue(100, 10);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (beats - b0 >= 3) break;
    end
    check("abort_three_beats", 32'(beats - b0), 32'd3);
    #1;
    abort = 1'b1;
    m_ready = 1'b0;
    #1;
    check("abort_rce_same_cycle", 32'(rce), 32'd0);
    exp_q.delete();
    exp_ra.delete();
    outstanding = 0;
    @(posedge clk);
    #1;
    abort = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("abort_done", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(m_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_valid_later", 32'(m_valid), 32'd0);
    check("abort_rce_later", 32'(rce), 32'd0);
    end_test("abort");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
